// File: rtl/cordic_post_unit.sv
// Final stage of the Sobel CORDIC vectoring chain: undoes the octant fold, compensates
// the CORDIC gain and produces magnitude, full-circle angle and an NMS direction bin.
module cordic_post_unit #(
  parameter int DW       = 16,
  parameter int DW_NOR   = 20,
  parameter int T_IR_NUM = 15,
  parameter int MAG_W    = 15,
  parameter int K_COEF   = 39797
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               oct_in,
  input  logic                     din_vsync,
  input  logic                     din_hsync,
  input  logic signed [DW-1:0]     din_x,
  input  logic signed [DW_NOR-1:0] din_z,
  output logic                     dout_vsync,
  output logic                     dout_hsync,
  output logic [MAG_W-1:0]         dout_mag,
  output logic [DW_NOR-1:0]        dout_ang,
  output logic [1:0]               dout_bin
);

  localparam int PROD_W = DW + 16;
  localparam int SH_W   = PROD_W - 15;

  localparam logic [DW_NOR-1:0] ANG_22  = DW_NOR'(1) << (DW_NOR - 4);
  localparam logic [DW_NOR-1:0] ANG_45  = DW_NOR'(1) << (DW_NOR - 3);
  localparam logic [DW_NOR-1:0] ANG_90  = DW_NOR'(1) << (DW_NOR - 2);
  localparam logic [DW_NOR-1:0] ANG_180 = DW_NOR'(1) << (DW_NOR - 1);
  localparam logic [PROD_W-1:0] K_EXT   = PROD_W'(K_COEF);
  localparam logic [PROD_W:0]   RND     = (PROD_W + 1)'(1) << 15;
  localparam logic [SH_W-1:0]   MAG_MAX = SH_W'((1 << MAG_W) - 1);

  // Octant flags ride a free-running line so they emerge alongside the chain's x/z.
  logic [2:0] oct_tap [T_IR_NUM+1];
  assign oct_tap[0] = oct_in;

  generate
    for (genvar gi = 0; gi < T_IR_NUM; gi++) begin : g_oct_line
      logic [2:0] stage_reg;
      always_ff @(posedge clk) begin
        if (rst) stage_reg <= '0;
        else     stage_reg <= oct_tap[gi];
      end
      assign oct_tap[gi+1] = stage_reg;
    end
  endgenerate

  logic [2:0]        oct_d;
  logic [DW-2:0]     x_c;
  logic [DW_NOR-1:0] z_u;
  logic [DW_NOR-1:0] z_c;
  logic [DW_NOR-1:0] a1;
  logic [DW_NOR-1:0] a2;
  logic [DW_NOR-1:0] a3_next;
  logic [PROD_W-1:0] prod_next;

  assign oct_d = oct_tap[T_IR_NUM];

  always_comb begin
    x_c = din_x[DW-1] ? '0 : din_x[DW-2:0];
    z_u = din_z;
    if (din_z[DW_NOR-1])   z_c = '0;
    else if (z_u > ANG_45) z_c = ANG_45;
    else                   z_c = z_u;
    a1        = oct_d[2] ? ANG_90 - z_c : z_c;
    a2        = oct_d[1] ? ANG_180 - a1 : a1;
    a3_next   = oct_d[0] ? '0 - a2 : a2;
    prod_next = PROD_W'(x_c) * K_EXT;
  end

  logic              vs1_reg;
  logic              hs1_reg;
  logic [PROD_W-1:0] prod_reg;
  logic [DW_NOR-1:0] a3_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs1_reg  <= 1'b0;
      hs1_reg  <= 1'b0;
      prod_reg <= '0;
      a3_reg   <= '0;
    end else begin
      vs1_reg <= din_vsync;
      hs1_reg <= din_hsync;
      if (din_hsync) begin
        prod_reg <= prod_next;
        a3_reg   <= a3_next;
      end else begin
        prod_reg <= '0;
        a3_reg   <= '0;
      end
    end
  end

  logic [PROD_W:0]  rnd_sum;
  logic [SH_W-1:0]  mag_full;
  logic [MAG_W-1:0] mag_next;
  logic [1:0]       bin_next;

  // Bin: shift by 22.5 deg, take the 45 deg sector index, keep it mod 4 (i.e. mod 180 deg).
  always_comb begin
    rnd_sum  = {1'b0, prod_reg} + RND;
    mag_full = SH_W'(rnd_sum >> 16);
    mag_next = (mag_full > MAG_MAX) ? MAG_W'(MAG_MAX) : MAG_W'(mag_full);
    bin_next = 2'((a3_reg + ANG_22) >> (DW_NOR - 3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vsync <= 1'b0;
      dout_hsync <= 1'b0;
      dout_mag   <= '0;
      dout_ang   <= '0;
      dout_bin   <= '0;
    end else begin
      dout_vsync <= vs1_reg;
      dout_hsync <= hs1_reg;
      if (hs1_reg) begin
        dout_mag <= mag_next;
        dout_ang <= a3_reg;
        dout_bin <= bin_next;
      end else begin
        dout_mag <= '0;
        dout_ang <= '0;
        dout_bin <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_post_unit.sv
// Randomised + directed scoreboard bench for cordic_post_unit; two instances cover
// the default configuration and a deeper chain (18 iterations) with a 14-bit magnitude.
module tb_cordic_post_unit;

  localparam int DW   = 16;
  localparam int DWN  = 20;
  localparam int TA   = 15;
  localparam int TB   = 18;
  localparam int MWA  = 15;
  localparam int MWB  = 14;
  localparam int N    = 560;
  localparam int FULL = 1 << DWN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [2:0]            oct_in;
  logic                  din_vsync;
  logic                  din_hsync;
  logic signed [DW-1:0]  din_x;
  logic signed [DWN-1:0] din_z;

  logic           oa_vs, oa_hs, ob_vs, ob_hs;
  logic [MWA-1:0] oa_mag;
  logic [MWB-1:0] ob_mag;
  logic [DWN-1:0] oa_ang, ob_ang;
  logic [1:0]     oa_bin, ob_bin;

  cordic_post_unit #(.DW(DW), .DW_NOR(DWN), .T_IR_NUM(TA), .MAG_W(MWA), .K_COEF(39797)) dut_a (
    .clk(clk), .rst(rst), .oct_in(oct_in), .din_vsync(din_vsync), .din_hsync(din_hsync),
    .din_x(din_x), .din_z(din_z), .dout_vsync(oa_vs), .dout_hsync(oa_hs),
    .dout_mag(oa_mag), .dout_ang(oa_ang), .dout_bin(oa_bin));

  cordic_post_unit #(.DW(DW), .DW_NOR(DWN), .T_IR_NUM(TB), .MAG_W(MWB), .K_COEF(39797)) dut_b (
    .clk(clk), .rst(rst), .oct_in(oct_in), .din_vsync(din_vsync), .din_hsync(din_hsync),
    .din_x(din_x), .din_z(din_z), .dout_vsync(ob_vs), .dout_hsync(ob_hs),
    .dout_mag(ob_mag), .dout_ang(ob_ang), .dout_bin(ob_bin));

  // Per-cycle stimulus plan; oct issued at cycle k belongs to the pixel at k+T.
  int p_oct [N];
  int p_x   [N];
  int p_z   [N];
  bit p_hs  [N];
  bit p_vs  [N];
  bit p_rst [N];

  typedef struct {
    int due; int hs; int vs; int mag; int ang; int bin;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_vec = 0;
  int n_err = 0;
  int cur_c = -1;

  // Reference: octant unfolding as quadrant geometry, magnitude as rounded real gain.
  function automatic exp_t model(int c, int t, int magw);
    exp_t e;
    int oct, zc, a, m, mmax;
    longint p;
    e = '{due: c + 2, hs: 0, vs: 0, mag: 0, ang: 0, bin: 0};
    if (p_rst[c] || (c + 1 < N && p_rst[c+1])) return e;
    e.vs = p_vs[c];
    e.hs = p_hs[c];
    if (!p_hs[c]) return e;
    oct = (c - t >= 0) ? p_oct[c-t] : 0;
    for (int j = c - t; j < c; j++)
      if (j >= 0 && p_rst[j]) oct = 0;
    zc = (p_z[c] < 0) ? 0 : ((p_z[c] > FULL / 8) ? FULL / 8 : p_z[c]);
    a = ((oct & 4) != 0) ? FULL / 4 - zc : zc;
    if ((oct & 2) != 0) a = FULL / 2 - a;
    if ((oct & 1) != 0) a = (FULL - a) % FULL;
    p = (p_x[c] > 0) ? longint'(p_x[c]) * 39797 : 64'd0;
    m = int'((p + 32768) / 65536);
    mmax = (1 << magw) - 1;
    if (m > mmax) m = mmax;
    e.mag = m;
    e.ang = a;
    e.bin = (((a + FULL / 16) % FULL) / (FULL / 8)) % 4;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cur_c, act, exp_v);
    end
  endtask

  task automatic cmp(string tag, exp_t e, int hs, int vs, int mag, int ang, int bin);
    $display("%s cyc=%0d hs=%0d vs=%0d mag=%0d ang=%0d bin=%0d", tag, cur_c, hs, vs, mag, ang, bin);
    chk({tag, "_hsync"}, hs, e.hs);
    chk({tag, "_vsync"}, vs, e.vs);
    chk({tag, "_mag"}, mag, e.mag);
    chk({tag, "_ang"}, ang, e.ang);
    chk({tag, "_bin"}, bin, e.bin);
  endtask

  // Monitor: pops whatever is due this cycle, independently of the driver.
  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].due <= cur_c) begin
      e = qa.pop_front();
      cmp("A", e, int'(oa_hs), int'(oa_vs), int'(oa_mag), int'(oa_ang), int'(oa_bin));
    end
    while (qb.size() > 0 && qb[0].due <= cur_c) begin
      e = qb.pop_front();
      cmp("B", e, int'(ob_hs), int'(ob_vs), int'(ob_mag), int'(ob_ang), int'(ob_bin));
    end
  end

  // Directed pixels: {oct, x, z}
  int d_oct [10] = '{0, 4, 0, 0, 0, 3, 1, 0, 5, 6};
  int d_x   [10] = '{165, 100, 200, 200, 200, 50, 50, 32767, -300, 30000};
  int d_z   [10] = '{0, 0, 131072, 131080, -5, 0, 65536, 0, 1000, 20000};

  initial begin
    for (int c = 0; c < N; c++) begin
      p_rst[c] = (c < 5);
      p_vs[c]  = 1'b1;
      p_hs[c]  = ($urandom_range(0, 9) != 0);
      p_oct[c] = int'($urandom_range(0, 7));
      p_x[c]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                             : int'($urandom_range(0, 32767));
      p_z[c]   = int'($urandom_range(0, 150000)) - 5000;
    end
    for (int c = 100; c < 110; c++) begin
      p_vs[c] = 1'b0;
      p_hs[c] = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      int c;
      c = 60 + 4 * i;
      p_hs[c] = 1'b1;
      p_x[c]  = d_x[i];
      p_z[c]  = d_z[i];
      p_oct[c-TA] = d_oct[i];
      p_oct[c-TB] = d_oct[i];
    end
    p_hs[100] = 1'b0;
    p_x[100]  = 20000;
    p_z[100]  = 70000;
    p_rst[300] = 1'b1;
    p_rst[301] = 1'b1;
    for (int c = 296; c < 340; c++) p_hs[c] = 1'b1;
    p_rst[450] = 1'b1;
    for (int c = N - 3; c < N; c++) p_hs[c] = 1'b0;

    for (int c = 0; c < N; c++) begin
      rst       = p_rst[c];
      oct_in    = 3'(p_oct[c]);
      din_vsync = p_vs[c];
      din_hsync = p_hs[c];
      din_x     = DW'(p_x[c]);
      din_z     = DWN'(p_z[c]);
      cur_c     = c;
      if (c < N - 2) begin
        qa.push_back(model(c, TA, MWA));
        qb.push_back(model(c, TB, MWB));
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
